// File: rtl/hbridge_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module : hbridge_cmd_gen
// Brief  : PWM enable / direction command generator for an H-bridge stage,
//          inserting a forced-off hold-off before every direction reversal.
// Rev    : 1.0  initial release
// ============================================================================
module hbridge_cmd_gen #(
    parameter int W       = 8,
    parameter int HOLDOFF = 12
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_duty,
    input  logic         cfg_dir,
    output logic         en,
    output logic         d,
    output logic         period_tick,
    output logic         busy
);

    localparam int c_HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [c_HW-1:0] c_HLAST = c_HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [c_HW-1:0] hcnt_q, hcnt_d;
    logic [W-1:0]    per_q, per_d;
    logic [W-1:0]    duty_q, duty_d;
    logic            dir_q, dir_d;

    logic            pend_q, pend_d;
    logic [W-1:0]    pend_per_q, pend_per_d;
    logic [W-1:0]    pend_duty_q, pend_duty_d;
    logic            pend_dir_q, pend_dir_d;

    logic            en_q, en_d;
    logic            d_q, d_d;
    logic            tick_q, tick_d;
    logic            busy_q, busy_d;

    logic            w_period_end;
    logic            w_drain;
    logic            w_load;

    assign w_period_end = (state_q == S_RUN) && (cnt_q == (per_q - W'(1)));

    // State / counter / active-setpoint next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        per_d   = per_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        w_drain = 1'b0;
        w_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    w_drain = 1'b1;
                    w_load  = (pend_per_q != '0);
                end
            end
            S_HOLD: begin
                if (hcnt_q == c_HLAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    hcnt_d = hcnt_q + c_HW'(1);
                end
            end
            S_RUN: begin
                if (w_period_end) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        w_drain = 1'b1;
                        // A stop request wins over any direction change.
                        if (pend_per_q == '0) begin
                            state_d = S_IDLE;
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            per_d   = pend_per_q;
            duty_d  = pend_duty_q;
            dir_d   = pend_dir_q;
            cnt_d   = '0;
            hcnt_d  = '0;
            state_d = (pend_dir_q == d_q) ? S_RUN : S_HOLD;
        end
    end

    // One-entry setpoint buffer; a handshake can only land while it is empty
    always_comb begin
        pend_d      = pend_q;
        pend_per_d  = pend_per_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        if (w_drain) begin
            pend_d = 1'b0;
        end
        if (cfg_valid && !pend_q) begin
            pend_d      = 1'b1;
            pend_per_d  = cfg_period;
            pend_duty_d = cfg_duty;
            pend_dir_d  = cfg_dir;
        end
    end

    // Outputs are registered images of the current state, so all of them
    // share the same one-cycle alignment relative to the internal counters.
    always_comb begin
        en_d   = (state_q == S_RUN) && (cnt_q < duty_q);
        tick_d = w_period_end;
        busy_d = (state_q != S_IDLE);
        d_d    = ((state_q == S_HOLD) && (hcnt_q == c_HLAST)) ? dir_q : d_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            per_q       <= '0;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_per_q  <= '0;
            pend_duty_q <= '0;
            pend_dir_q  <= 1'b0;
            en_q        <= 1'b0;
            d_q         <= 1'b0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            per_q       <= per_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            pend_per_q  <= pend_per_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            en_q        <= en_d;
            d_q         <= d_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_ready   = !pend_q;
    assign en          = en_q;
    assign d           = d_q;
    assign period_tick = tick_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_hbridge_cmd_gen
// Brief  : Self-checking bench for hbridge_cmd_gen against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hbridge_cmd_gen;

    localparam int W       = 8;
    localparam int HOLDOFF = 12;
    localparam int ST_IDLE = 0;
    localparam int ST_HOLD = 1;
    localparam int ST_RUN  = 2;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;
    logic         cfg_dir;
    logic         en;
    logic         d;
    logic         period_tick;
    logic         busy;

    hbridge_cmd_gen #(.W(W), .HOLDOFF(HOLDOFF)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_dir     (cfg_dir),
        .en          (en),
        .d           (d),
        .period_tick (period_tick),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Behavioural model: what the outputs show after each clock edge
    bit m_en, m_d, m_tick, m_busy, m_pend;
    int m_state, m_cnt, m_hleft, m_per, m_duty, m_dir;
    int m_pper, m_pduty, m_pdir;

    int   zero_run;
    logic prev_d;

    function automatic logic [4:0] dut_vec();
        return {en, d, period_tick, busy, cfg_ready};
    endfunction

    function automatic logic [4:0] mdl_vec();
        return {m_en, m_d, m_tick, m_busy, ~m_pend};
    endfunction

    task automatic model_reset();
        m_en = 0; m_d = 0; m_tick = 0; m_busy = 0; m_pend = 0;
        m_state = ST_IDLE; m_cnt = 0; m_hleft = 0;
        m_per = 0; m_duty = 0; m_dir = 0;
        zero_run = HOLDOFF;
        prev_d   = 1'b0;
    endtask

    task automatic model_take();
        m_per  = m_pper;
        m_duty = m_pduty;
        m_dir  = m_pdir;
        m_cnt  = 0;
        if (m_pdir == int'(m_d)) m_state = ST_RUN;
        else begin
            m_state = ST_HOLD;
            m_hleft = HOLDOFF;
        end
    endtask

    task automatic model_step(input bit hs);
        m_en   = (m_state == ST_RUN) && (m_cnt < m_duty);
        m_tick = (m_state == ST_RUN) && (m_cnt == m_per - 1);
        m_busy = (m_state != ST_IDLE);
        if (m_state == ST_HOLD && m_hleft == 1) m_d = m_dir[0];
        case (m_state)
            ST_IDLE: begin
                if (m_pend) begin
                    m_pend = 0;
                    if (m_pper != 0) model_take();
                end
            end
            ST_HOLD: begin
                if (m_hleft == 1) begin
                    m_state = ST_RUN;
                    m_cnt   = 0;
                end else m_hleft--;
            end
            default: begin
                if (m_cnt == m_per - 1) begin
                    m_cnt = 0;
                    if (m_pend) begin
                        m_pend = 0;
                        if (m_pper == 0) m_state = ST_IDLE;
                        else model_take();
                    end
                end else m_cnt++;
            end
        endcase
        if (hs) begin
            m_pend  = 1;
            m_pper  = int'(cfg_period);
            m_pduty = int'(cfg_duty);
            m_pdir  = int'(cfg_dir);
        end
    endtask

    // Advance one clock: model update, drop valid after a handshake,
    // and watch that d only moves after HOLDOFF cycles of en low.
    task automatic tick();
        bit hs;
        @(posedge sys_clk);
        hs = sys_rst_n && cfg_valid && !m_pend;
        if (sys_rst_n) model_step(hs);
        #1;
        if (hs) cfg_valid = 1'b0;
        if (sys_rst_n) begin
            if (en) zero_run = 0;
            else zero_run++;
            if (d !== prev_d) begin
                n_asrt++;
                if (en || zero_run < HOLDOFF) begin
                    n_fail++;
                    $display("FAIL safety t=%0t: d changed with en=%b after %0d low cycles, required >= %0d",
                             $time, en, zero_run, HOLDOFF);
                end
            end
            prev_d = d;
        end
    endtask

    task automatic offer(input int p, input int du, input int dr);
        cfg_period = W'(p);
        cfg_duty   = W'(du);
        cfg_dir    = dr[0];
        cfg_valid  = 1'b1;
    endtask

    task automatic test_reset();
        cfg_valid = 0; cfg_period = '0; cfg_duty = '0; cfg_dir = 0;
        sys_rst_n = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        n_asrt++;
        if (dut_vec() !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_async: en,d,tick,busy,rdy got %b expected 00001", dut_vec());
        end
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (4) begin
            tick();
            n_asrt++;
            if (dut_vec() !== 5'b00001) begin
                n_fail++;
                $display("FAIL reset_idle: en,d,tick,busy,rdy got %b expected 00001", dut_vec());
            end
        end
    endtask

    task automatic test_basic();
        logic [19:0] en_seq, tk_seq, en_exp, tk_exp;
        offer(10, 4, 0);
        tick();
        n_asrt++;
        if (dut_vec() !== 5'b00000) begin
            n_fail++;
            $display("FAIL start_accept: en,d,tick,busy,rdy got %b expected 00000", dut_vec());
        end
        tick();
        n_asrt++;
        if (dut_vec() !== 5'b00001) begin
            n_fail++;
            $display("FAIL start_drain: en,d,tick,busy,rdy got %b expected 00001", dut_vec());
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            en_seq[i] = en;
            tk_seq[i] = period_tick;
            en_exp[i] = ((i % 10) < 4);
            tk_exp[i] = ((i % 10) == 9);
            n_asrt++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL basic_model t=%0t: got %b expected %b", $time, dut_vec(), mdl_vec());
            end
        end
        n_asrt++;
        if (en_seq !== en_exp) begin
            n_fail++;
            $display("FAIL basic_en_pattern: got %b expected %b", en_seq, en_exp);
        end
        n_asrt++;
        if (tk_seq !== tk_exp) begin
            n_fail++;
            $display("FAIL basic_tick_pattern: got %b expected %b", tk_seq, tk_exp);
        end
    endtask

    task automatic test_duty_change();
        bit got;
        logic [9:0] en_seq, en_exp;
        offer(10, 7, 0);
        repeat (25) begin
            tick();
            n_asrt++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL duty_model t=%0t: got %b expected %b", $time, dut_vec(), mdl_vec());
            end
        end
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            got = period_tick;
        end
        n_asrt++;
        if (!got) begin
            n_fail++;
            $display("FAIL duty_tick_timeout: period_tick got 0 expected 1 within 12 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            en_seq[i] = en;
            en_exp[i] = (i < 7);
        end
        n_asrt++;
        if (en_seq !== en_exp) begin
            n_fail++;
            $display("FAIL duty_en_pattern: got %b expected %b", en_seq, en_exp);
        end
    endtask

    task automatic test_dir_change();
        bit got, xe, xd;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            got = period_tick;
        end
        n_asrt++;
        if (!got) begin
            n_fail++;
            $display("FAIL dir_tick_timeout: period_tick got 0 expected 1 within 12 cycles");
        end
        offer(10, 7, 1);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k <= 10) begin
                xe = ((k - 1) < 7); xd = 0;
            end else if (k <= 22) begin
                xe = 0; xd = (k == 22);
            end else begin
                xe = ((k - 23) < 7); xd = 1;
            end
            n_asrt++;
            if ({en, d} !== {xe, xd}) begin
                n_fail++;
                $display("FAIL dir_seq cycle %0d: en,d got %b%b expected %b%b", k, en, d, xe, xd);
            end
            n_asrt++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL dir_model t=%0t: got %b expected %b", $time, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_edge_duty();
        int duties[3] = '{0, 10, 255};
        int ones, ticks;
        foreach (duties[j]) begin
            offer(10, duties[j], 1);
            ones = 0; ticks = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (i >= 20) begin
                    ones  += int'(en);
                    ticks += int'(period_tick);
                end
                n_asrt++;
                if (dut_vec() !== mdl_vec()) begin
                    n_fail++;
                    $display("FAIL edge_model duty=%0d: got %b expected %b", duties[j], dut_vec(), mdl_vec());
                end
            end
            n_asrt++;
            if (ones != ((duties[j] == 0) ? 0 : 20)) begin
                n_fail++;
                $display("FAIL edge_en_count duty=%0d: got %0d expected %0d",
                         duties[j], ones, (duties[j] == 0) ? 0 : 20);
            end
            n_asrt++;
            if (ticks != 2) begin
                n_fail++;
                $display("FAIL edge_tick_count duty=%0d: got %0d expected 2", duties[j], ticks);
            end
        end
    endtask

    task automatic test_stall_stop();
        bit seen;
        offer(10, 3, 1);
        tick();
        n_asrt++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full: cfg_ready got %b expected 0", cfg_ready);
        end
        offer(0, 5, 0);
        seen = 0;
        for (int i = 0; i < 30 && cfg_valid; i++) begin
            tick();
            if (cfg_ready && !seen) begin
                seen = 1;
                n_asrt++;
                if (period_tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_ready_align: period_tick got %b expected 1 when ready returns", period_tick);
                end
            end
            n_asrt++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL stall_model t=%0t: got %b expected %b", $time, dut_vec(), mdl_vec());
            end
        end
        n_asrt++;
        if (cfg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept_timeout: stop setpoint still pending, valid got %b expected 0", cfg_valid);
        end
        repeat (25) begin
            tick();
            n_asrt++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL stop_model t=%0t: got %b expected %b", $time, dut_vec(), mdl_vec());
            end
        end
        n_asrt++;
        if ({en, busy, d} !== 3'b001) begin
            n_fail++;
            $display("FAIL stop_idle: en,busy,d got %b expected 001", {en, busy, d});
        end
    endtask

    task automatic test_async_reset();
        offer(10, 10, 1);
        repeat (12) tick();
        n_asrt++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre_en: en got %b expected 1", en);
        end
        offer(20, 5, 0);
        tick();
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        n_asrt++;
        if (dut_vec() !== 5'b00001) begin
            n_fail++;
            $display("FAIL areset_immediate: en,d,tick,busy,rdy got %b expected 00001", dut_vec());
        end
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (15) begin
            tick();
            n_asrt++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL areset_model t=%0t: got %b expected %b", $time, dut_vec(), mdl_vec());
            end
        end
        n_asrt++;
        if ({en, d, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_pending_lost: en,d,busy got %b expected 000", {en, d, busy});
        end
    endtask

    task automatic test_random();
        int r, p;
        for (int it = 0; it < 60; it++) begin
            if (!cfg_valid) begin
                r = int'($urandom_range(0, 15));
                if (r == 0)      p = 0;
                else if (r == 1) p = 1;
                else if (r == 2) p = 255;
                else             p = int'($urandom_range(2, 24));
                offer(p, int'($urandom_range(0, 30)), int'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(1, 30)) begin
                tick();
                n_asrt++;
                if (dut_vec() !== mdl_vec()) begin
                    n_fail++;
                    $display("FAIL random_model t=%0t: got %b expected %b", $time, dut_vec(), mdl_vec());
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_dir_change();
        test_edge_duty();
        test_stall_stop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hbridge_cmd_gen.md
# hbridge_cmd_gen

Command generator driving the enable/direction inputs (`en`, `d`) of the H-bridge output stage. It converts a (period, duty, direction) setpoint into a PWM enable waveform and a direction level. Every direction reversal is preceded by a forced-off hold-off interval, so the bridge's own dead-time counter always expires before the new direction is driven. It sits between the control/host register logic and the bridge driver, in the single system clock domain.

## Interface
- `W`, default 8: width of period/duty fields and the internal counter.
- `HOLDOFF`, default 12: cycles `en` is forced low before `d` may change. Must exceed the bridge dead-time of 10.
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: the new setpoint on `cfg_*` is valid.
- `cfg_ready` out 1: the setpoint buffer can accept a setpoint.
- `cfg_period` in W: PWM period in cycles. 0 = stop.
- `cfg_duty` in W: number of cycles per period with `en` high.
- `cfg_dir` in 1: requested direction, driven onto `d`.
- `en` out 1: bridge enable (registered).
- `d` out 1: bridge direction (registered).
- `period_tick` out 1: one-cycle pulse in the last cycle of each RUN period (registered).
- `busy` out 1: high in RUN or HOLDOFF.

## Operation
- **Setpoint buffer.** One-entry pending buffer.
  - Handshake when `cfg_valid && cfg_ready`.
  - `cfg_ready` = buffer empty.
  - `cfg_valid` held while `cfg_ready` is low is stalled, not dropped.
  - The buffer drains per the state rules below. `cfg_ready` returns high the cycle after the drain.
- **States:** IDLE, HOLDOFF, RUN.
- **IDLE**
  - `en` = 0, `d` holds its last value.
  - A pending setpoint with `cfg_period` = 0 drains with no effect.
  - A pending setpoint with nonzero period and `cfg_dir` == `d` drains and goes to RUN, counter `cnt` = 0.
  - A pending setpoint with nonzero period and `cfg_dir` != `d` drains and goes to HOLDOFF.
- **HOLDOFF**
  - `en` = 0 and the hold-off counter runs `HOLDOFF` cycles.
  - In the final hold-off cycle, `d` takes the new direction. The next cycle enters RUN with `cnt` = 0.
  - A pending setpoint arriving during HOLDOFF is not applied until the next RUN period boundary.
- **RUN**
  - `cnt` counts 0..period−1 and wraps to 0.
  - In the cycle where `cnt` == k, `en` = (k < duty).
  - duty ≥ period gives `en` constantly high. duty = 0 gives `en` constantly low.
  - `period_tick` = 1 when `cnt` == period−1.
  - At the period end, with a setpoint pending, the buffer drains:
    - period = 0 → IDLE.
    - Direction change → HOLDOFF.
    - Otherwise the new period/duty take effect from `cnt` = 0 of the next period, with no glitch and no extra cycle.
  - Without a pending setpoint the current setpoint repeats.
- **Safety invariant:** `d` never changes while `en` = 1, or within `HOLDOFF` cycles after `en` was last 1.
- **Arithmetic:** `cnt` and the comparisons are unsigned `W`-bit. A period of 2^W−1 is the maximum. No overflow states.

## Timing
- **Reset values** (asynchronous on `sys_rst_n` low, immediately, regardless of state):
  - `en` = 0, `d` = 0, `period_tick` = 0, `busy` = 0.
  - `cfg_ready` = 1, state IDLE, buffer empty.
- **Reset mid-RUN:** `en` drops asynchronously and the pending setpoint is discarded.
- **IDLE start latency:** handshake at edge N → buffer drained at edge N+1 → first RUN cycle (`cnt` = 0, `en` valid) after edge N+2.
- **HOLDOFF:** exactly `HOLDOFF` cycles with `en` = 0, then RUN.
- **Simultaneous events:**
  - A handshake in the same cycle as a period end goes to the buffer. It drains at the following period end, not the current one.
  - A period end with a pending stop and a direction change together: stop wins (IDLE, `d` unchanged).

## Test plan
1. Reset, then setpoint period=10, duty=4, dir=0 → RUN from edge N+2; `en` pattern 1111000000 repeating; `period_tick` every 10 cycles; `d`=0.
2. While running, setpoint period=10, duty=7, dir=0 → `en` pattern unchanged until the period end, then 1111111000 from the next `cnt`=0; no HOLDOFF.
3. Running dir=0, setpoint dir=1 → at the period end `en`=0 for 12 cycles, `d` goes 0→1 only in the 12th, then RUN; a checker confirms the safety invariant.
4. Edge duties: duty=0 → `en` never high; duty=10 and duty=255 with period=10 → `en` constantly high; `period_tick` still every 10.
5. Second `cfg_valid` while the buffer is full → `cfg_ready`=0, valid stalled, accepted right after drain; stop setpoint (period=0) → IDLE at the period end, `busy`=0, `en`=0.
6. Assert `sys_rst_n` low mid-RUN with `en`=1 → `en` 0 in the same cycle (asynchronous), pending setpoint lost, all outputs at reset values.
